// File: rtl/pwr_sweep_sched.sv
// Power-sweep sequencer: steps the active-slice count 0..N_DUT, holding a settle
// interval then a flagged measurement window at each step (optionally twice, opt off/on).
module pwr_sweep_sched #(
    parameter int unsigned N_DUT    = 32,
    parameter int unsigned SETTLE_W = 16,
    parameter int unsigned DWELL_W  = 32
) (
    input  logic                clk100m,
    input  logic                rstn,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic [DWELL_W-1:0]  dwell_cycles,
    input  logic [1:0]          opt_sel,
    output logic [N_DUT-1:0]    pwr_en_out,
    output logic [N_DUT-1:0]    opt_en_out,
    output logic                busy,
    output logic                done,
    output logic                meas_active,
    output logic [5:0]          step_idx,
    output logic                opt_phase
);

    localparam int unsigned CNT_W = (SETTLE_W > DWELL_W) ? SETTLE_W : DWELL_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [SETTLE_W-1:0] r_settle;
    logic [DWELL_W-1:0]  r_dwell;
    logic [1:0]          r_opt_sel;
    logic [5:0]          r_k;
    logic                r_phase;
    logic [N_DUT-1:0]    r_pwr;
    logic [N_DUT-1:0]    r_opt;
    logic                r_busy;
    logic                r_done;
    logic                r_meas;

    logic [5:0]          w_nk;
    logic                w_nph;
    logic                w_last;

    function automatic logic [N_DUT-1:0] therm(input logic [5:0] k);
        logic [N_DUT-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N_DUT; i++) begin
            m[i] = (i < 32'(k));
        end
        return m;
    endfunction

    // A zero dwell still produces a one-cycle measurement window.
    function automatic logic [CNT_W-1:0] dwell_len(input logic [DWELL_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : CNT_W'(d);
    endfunction

    // Step/phase that follows the current measurement window.
    always_comb begin
        w_nk   = r_k;
        w_nph  = 1'b1;
        w_last = 1'b0;
        if (r_opt_sel[1] && !r_phase) begin
            w_nk  = r_k;
            w_nph = 1'b1;
        end else if (r_k < 6'(N_DUT)) begin
            w_nk  = r_k + 6'd1;
            w_nph = (r_opt_sel == 2'd1);
        end else begin
            w_last = 1'b1;
        end
    end

    always_ff @(posedge clk100m) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_settle  <= '0;
            r_dwell   <= '0;
            r_opt_sel <= '0;
            r_k       <= '0;
            r_phase   <= 1'b0;
            r_pwr     <= '0;
            r_opt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_meas    <= 1'b0;
        end else if (abort && r_state != S_IDLE) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_phase <= 1'b0;
            r_pwr   <= '0;
            r_opt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_meas  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !abort) begin
                        r_settle  <= settle_cycles;
                        r_dwell   <= dwell_cycles;
                        r_opt_sel <= opt_sel;
                        r_k       <= '0;
                        r_phase   <= (opt_sel == 2'd1);
                        r_pwr     <= '0;
                        r_opt     <= '0;
                        r_busy    <= 1'b1;
                        if (settle_cycles == '0) begin
                            r_state <= S_MEASURE;
                            r_cnt   <= dwell_len(dwell_cycles);
                            r_meas  <= 1'b1;
                        end else begin
                            r_state <= S_SETTLE;
                            r_cnt   <= CNT_W'(settle_cycles);
                            r_meas  <= 1'b0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_MEASURE;
                        r_cnt   <= dwell_len(r_dwell);
                        r_meas  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (r_cnt != CNT_W'(1)) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (w_last) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_k     <= '0;
                        r_phase <= 1'b0;
                        r_pwr   <= '0;
                        r_opt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_meas  <= 1'b0;
                    end else begin
                        r_k     <= w_nk;
                        r_phase <= w_nph;
                        r_pwr   <= therm(w_nk);
                        r_opt   <= w_nph ? therm(w_nk) : '0;
                        if (r_settle == '0) begin
                            r_state <= S_MEASURE;
                            r_cnt   <= dwell_len(r_dwell);
                            r_meas  <= 1'b1;
                        end else begin
                            r_state <= S_SETTLE;
                            r_cnt   <= CNT_W'(r_settle);
                            r_meas  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pwr_en_out  = r_pwr;
    assign opt_en_out  = r_opt;
    assign busy        = r_busy;
    assign done        = r_done;
    assign meas_active = r_meas;
    assign step_idx    = r_k;
    assign opt_phase   = r_phase;

endmodule

// File: tb/tb_pwr_sweep_sched.sv
// Bench for pwr_sweep_sched: a per-cycle expected trace is built from the sweep
// rules (steps x phases x settle/dwell lengths) and compared cycle by cycle.
module tb_pwr_sweep_sched;

    localparam int N  = 4;
    localparam int SW = 4;
    localparam int DW = 3;

    logic          clk100m = 1'b0;
    logic          rstn    = 1'b0;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic [SW-1:0] settle_cycles = '0;
    logic [DW-1:0] dwell_cycles  = '0;
    logic [1:0]    opt_sel       = '0;
    logic [N-1:0]  pwr_en_out;
    logic [N-1:0]  opt_en_out;
    logic          busy;
    logic          done;
    logic          meas_active;
    logic [5:0]    step_idx;
    logic          opt_phase;

    pwr_sweep_sched #(
        .N_DUT   (N),
        .SETTLE_W(SW),
        .DWELL_W (DW)
    ) dut (
        .clk100m      (clk100m),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .settle_cycles(settle_cycles),
        .dwell_cycles (dwell_cycles),
        .opt_sel      (opt_sel),
        .pwr_en_out   (pwr_en_out),
        .opt_en_out   (opt_en_out),
        .busy         (busy),
        .done         (done),
        .meas_active  (meas_active),
        .step_idx     (step_idx),
        .opt_phase    (opt_phase)
    );

    always #5 clk100m = ~clk100m;

    int total = 0;
    int bad   = 0;
    logic [17:0] exp_q[$];

    // {pwr[17:14], opt[13:10], busy[9], done[8], meas[7], step[6:1], phase[0]}
    function automatic logic [17:0] pack(input logic [3:0] p, input logic [3:0] o,
                                         input logic b, input logic d, input logic m,
                                         input logic [5:0] s, input logic ph);
        return {p, o, b, d, m, s, ph};
    endfunction

    function automatic logic [17:0] obs();
        return pack(pwr_en_out, opt_en_out, busy, done, meas_active, step_idx, opt_phase);
    endfunction

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference trace: every cycle from t+1 through the done pulse.
    task automatic build(input int st, input int dw, input int os);
        int t;
        int nph;
        int ph;
        int len;
        logic [3:0] m;
        logic [3:0] o;
        exp_q.delete();
        nph = (os >= 2) ? 2 : 1;
        len = (dw == 0) ? 1 : dw;
        for (int k = 0; k <= N; k++) begin
            t = (1 << k) - 1;
            m = t[3:0];
            for (int p = 0; p < nph; p++) begin
                ph = (os >= 2) ? p : ((os == 1) ? 1 : 0);
                o  = (ph != 0) ? m : 4'd0;
                for (int c = 0; c < st; c++)
                    exp_q.push_back(pack(m, o, 1'b1, 1'b0, 1'b0, 6'(k), ph[0]));
                for (int c = 0; c < len; c++)
                    exp_q.push_back(pack(m, o, 1'b1, 1'b0, 1'b1, 6'(k), ph[0]));
            end
        end
        exp_q.push_back(pack(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0));
    endtask

    // stop_at: -1 none, -2 first step-2 measure cycle, else trace index.
    task automatic run_sweep(input int st, input int dw, input int os,
                             input int stop_at, input bit inject, input bit use_rst);
        int stop;
        build(st, dw, os);
        stop = stop_at;
        if (stop_at == -2) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i][6:1] == 6'd2 && exp_q[i][7]) begin
                    stop = i;
                    break;
                end
            end
        end
        @(negedge clk100m);
        settle_cycles = SW'(st);
        dwell_cycles  = DW'(dw);
        opt_sel       = 2'(os);
        start = 1'b1;
        abort = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk100m);
            chk($sformatf("cyc%0d", i), obs(), exp_q[i]);
            start = inject && ($urandom_range(0, 5) == 0);
            settle_cycles = SW'($urandom);
            dwell_cycles  = DW'($urandom);
            opt_sel       = 2'($urandom);
            if (i == stop) begin
                if (use_rst) rstn = 1'b0;
                else begin
                    abort = 1'b1;
                    start = 1'($urandom_range(0, 1));
                end
                break;
            end
        end
        @(negedge clk100m);
        chk(stop >= 0 ? "post_stop" : "post_done", obs(), 18'd0);
        start = 1'b0;
        abort = 1'b0;
        rstn  = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk100m);
        chk("reset", obs(), 18'd0);
        rstn = 1'b1;

        run_sweep(2, 3, 0, -1, 1'b0, 1'b0);
        run_sweep(0, 1, 2, -1, 1'b0, 1'b0);
        run_sweep(0, 0, 1, -1, 1'b0, 1'b0);
        run_sweep(2, 3, 0, -2, 1'b0, 1'b0);
        run_sweep(1, 2, 3, -1, 1'b1, 1'b0);
        run_sweep(15, 7, 3, -1, 1'b1, 1'b0);
        run_sweep(3, 2, 2, 17, 1'b0, 1'b1);

        @(negedge clk100m);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk100m);
        chk("sa_idle", obs(), 18'd0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk100m);
        chk("sa_idle2", obs(), 18'd0);

        for (int n = 0; n < 20; n++) begin
            int st;
            int dw;
            int os;
            int sa;
            st = $urandom_range(0, 15);
            dw = $urandom_range(0, 7);
            os = $urandom_range(0, 3);
            sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            run_sweep(st, dw, os, sa, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
